// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard/bypass interface: decoded instruction fields in, pipeline
// control and forwarding selects out.
interface pipe_hazard_ctrl_if #(
  parameter int RADDR_W = 5,
  parameter int LAT_W   = 2,
  parameter int FSEL_W  = 2,
  parameter int CNT_W   = 16
);
  logic               id_valid_i;
  logic [RADDR_W-1:0] id_rs1_i;
  logic [RADDR_W-1:0] id_rs2_i;
  logic               id_rs1_used_i;
  logic               id_rs2_used_i;
  logic               id_rd_we_i;
  logic [RADDR_W-1:0] id_rd_i;
  logic [LAT_W-1:0]   id_rdy_i;
  logic               br_taken_i;
  logic               stall_o;
  logic               flush_o;
  logic [FSEL_W-1:0]  fwd_rs1_sel_o;
  logic [FSEL_W-1:0]  fwd_rs2_sel_o;
  logic [CNT_W-1:0]   stall_cnt_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_we_i, id_rd_i, id_rdy_i, br_taken_i,
    input  stall_o, flush_o, fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_we_i, id_rd_i, id_rdy_i, br_taken_i,
    output stall_o, flush_o, fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Tracks in-flight destination registers behind ID and derives stall, flush,
// forwarding selects and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int RADDR_W  = 5,
  parameter int DEPTH    = 3,
  parameter int BR_STAGE = 1,
  parameter int LAT_W    = 2,
  parameter int FSEL_W   = 2,
  parameter int CNT_W    = 16
) (
  input logic              clk_i,
  input logic              rst_n_i,
  pipe_hazard_ctrl_if.slave bus
);

  logic [DEPTH-1:0]   valid_r;
  logic [RADDR_W-1:0] rd_r  [DEPTH];
  logic [LAT_W-1:0]   rdy_r [DEPTH];
  logic [CNT_W-1:0]   stall_cnt_r;

  logic               rs1_match_s;
  logic               rs2_match_s;
  logic [LAT_W-1:0]   rs1_k_s;
  logic [LAT_W-1:0]   rs2_k_s;
  logic [LAT_W-1:0]   rs1_rdy_s;
  logic [LAT_W-1:0]   rs2_rdy_s;
  logic               rs1_hz_s;
  logic               rs2_hz_s;
  logic [FSEL_W-1:0]  rs1_sel_s;
  logic [FSEL_W-1:0]  rs2_sel_s;
  logic               flush_s;
  logic               stall_s;

  // Youngest-match search: scan oldest to youngest so the lowest k wins.
  always_comb begin
    rs1_match_s = 1'b0;
    rs2_match_s = 1'b0;
    rs1_k_s     = '0;
    rs2_k_s     = '0;
    rs1_rdy_s   = '0;
    rs2_rdy_s   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (bus.id_rs1_used_i && (bus.id_rs1_i != '0) && valid_r[k] &&
          (rd_r[k] == bus.id_rs1_i)) begin
        rs1_match_s = 1'b1;
        rs1_k_s     = LAT_W'(k);
        rs1_rdy_s   = rdy_r[k];
      end else begin
        rs1_match_s = rs1_match_s;
      end
      if (bus.id_rs2_used_i && (bus.id_rs2_i != '0) && valid_r[k] &&
          (rd_r[k] == bus.id_rs2_i)) begin
        rs2_match_s = 1'b1;
        rs2_k_s     = LAT_W'(k);
        rs2_rdy_s   = rdy_r[k];
      end else begin
        rs2_match_s = rs2_match_s;
      end
    end
  end

  // Per-source decision: forward when the result already sits in entry k, else hazard.
  always_comb begin
    rs1_hz_s  = 1'b0;
    rs2_hz_s  = 1'b0;
    rs1_sel_s = '0;
    rs2_sel_s = '0;
    if (rs1_match_s && (rs1_k_s >= rs1_rdy_s)) begin
      rs1_sel_s = FSEL_W'(rs1_k_s) + FSEL_W'(1);
    end else if (rs1_match_s) begin
      rs1_hz_s = 1'b1;
    end else begin
      rs1_sel_s = '0;
    end
    if (rs2_match_s && (rs2_k_s >= rs2_rdy_s)) begin
      rs2_sel_s = FSEL_W'(rs2_k_s) + FSEL_W'(1);
    end else if (rs2_match_s) begin
      rs2_hz_s = 1'b1;
    end else begin
      rs2_sel_s = '0;
    end
  end

  // A taken branch only counts when its entry is real; flush beats stall.
  always_comb begin
    flush_s = bus.br_taken_i & valid_r[BR_STAGE];
    stall_s = bus.id_valid_i & (rs1_hz_s | rs2_hz_s) & ~flush_s;
  end

  // Shift register of in-flight writers; wrong-path entries die on flush.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_r[k]  <= '0;
        rdy_r[k] <= '0;
      end
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        valid_r[k] <= valid_r[k-1] & ~(flush_s & ((k - 1) < BR_STAGE));
        rd_r[k]    <= rd_r[k-1];
        rdy_r[k]   <= rdy_r[k-1];
      end
      valid_r[0] <= bus.id_valid_i & bus.id_rd_we_i & (bus.id_rd_i != '0) &
                    ~stall_s & ~flush_s;
      rd_r[0]    <= bus.id_rd_i;
      rdy_r[0]   <= bus.id_rdy_i;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_r <= '0;
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall_o       = stall_s;
  assign bus.flush_o       = flush_s;
  assign bus.fwd_rs1_sel_o = rs1_sel_s;
  assign bus.fwd_rs2_sel_o = rs2_sel_s;
  assign bus.stall_cnt_o   = stall_cnt_r;

endmodule
